// File: rtl/bmp_pkg.sv
// Shared types, constants and geometry helpers for the BMP stream writer.
package bmp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_PIX  = 3'd2,
    ST_PAD  = 3'd3,
    ST_FIN  = 3'd4
  } state_e;

  localparam int HDR_BYTES = 54;

  // Rows are padded so that each row occupies a multiple of four bytes.
  function automatic logic [1:0] pad_bytes(input logic [11:0] w);
    logic [13:0] rb;
    rb = 14'(w) * 14'd3;
    return 2'(3'd4 - {1'b0, rb[1:0]});
  endfunction

  function automatic logic [31:0] row_bytes(input logic [11:0] w);
    return 32'(w) * 32'd3 + 32'(pad_bytes(w));
  endfunction

  function automatic logic [31:0] image_bytes(input logic [11:0] w, input logic [11:0] h);
    return row_bytes(w) * 32'(h);
  endfunction

  function automatic logic [31:0] file_bytes(input logic [11:0] w, input logic [11:0] h);
    return 32'(HDR_BYTES) + image_bytes(w, h);
  endfunction

  function automatic logic [7:0] gray_byte(input logic [23:0] p);
    logic [9:0] s;
    s = 10'(p[23:16]) + {1'b0, p[15:8], 1'b0} + 10'(p[7:0]);
    return s[9:2];
  endfunction

endpackage

// File: rtl/bmp_header_rom.sv
// Combinational 54-byte BMP/DIB header generator; little-endian fields derived
// from the image dimensions.
module bmp_header_rom
  import bmp_pkg::*;
(
  input  logic [5:0]  idx_i,
  input  logic [11:0] width_i,
  input  logic [11:0] height_i,
  output logic [7:0]  data_o
);

  logic [31:0] fsize_s;
  logic [31:0] isize_s;

  // Header byte lookup by index.
  always_comb begin
    fsize_s = file_bytes(width_i, height_i);
    isize_s = image_bytes(width_i, height_i);
    data_o  = 8'h00;
    case (idx_i)
      6'd0:  data_o = 8'h42;
      6'd1:  data_o = 8'h4D;
      6'd2:  data_o = fsize_s[7:0];
      6'd3:  data_o = fsize_s[15:8];
      6'd4:  data_o = fsize_s[23:16];
      6'd5:  data_o = fsize_s[31:24];
      6'd10: data_o = 8'd54;
      6'd14: data_o = 8'd40;
      6'd18: data_o = width_i[7:0];
      6'd19: data_o = {4'h0, width_i[11:8]};
      6'd22: data_o = height_i[7:0];
      6'd23: data_o = {4'h0, height_i[11:8]};
      6'd26: data_o = 8'd1;
      6'd28: data_o = 8'd24;
      6'd34: data_o = isize_s[7:0];
      6'd35: data_o = isize_s[15:8];
      6'd36: data_o = isize_s[23:16];
      6'd37: data_o = isize_s[31:24];
      default: data_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/bmp_stream_writer.sv
// Streams a 24-bit BMP file (header, B/G/R pixel bytes, row padding) as bytes.
// Define BMP_GRAYSCALE_EN to replace each colour byte with luma (R+2G+B)>>2.
module bmp_stream_writer
  import bmp_pkg::*;
#(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [23:0] pix_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  localparam logic [11:0] W_M1  = 12'(WIDTH - 1);
  localparam logic [11:0] H_M1  = 12'(HEIGHT - 1);
  localparam logic [1:0]  PAD_N = pad_bytes(12'(WIDTH));
  localparam logic [1:0]  PAD_M1 = PAD_N - 2'd1;

  state_e      state_q, state_d;
  logic [5:0]  hdr_idx_q, hdr_idx_d;
  logic [11:0] col_q, col_d;
  logic [11:0] row_q, row_d;
  logic [1:0]  sel_q, sel_d;
  logic [1:0]  pad_q, pad_d;
  logic [23:0] hold_q, hold_d;
  logic        full_q, full_d;

  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_last_q, out_last_d;
  logic        pix_ready_q, pix_ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        xfer_s, cap_s, last_col_s, last_row_s;
  logic [7:0]  hdr_byte_s, pix_byte_s;

  bmp_header_rom u_hdr (
    .idx_i    (hdr_idx_d),
    .width_i  (12'(WIDTH)),
    .height_i (12'(HEIGHT)),
    .data_o   (hdr_byte_s)
  );

  // Next-state: FSM sequencing and counters, advanced only by handshakes.
  always_comb begin
    state_d    = state_q;
    hdr_idx_d  = hdr_idx_q;
    col_d      = col_q;
    row_d      = row_q;
    sel_d      = sel_q;
    pad_d      = pad_q;
    hold_d     = hold_q;
    full_d     = full_q;
    xfer_s     = out_valid_q && out_ready;
    cap_s      = pix_valid && pix_ready_q;
    last_col_s = (col_q == W_M1);
    last_row_s = (row_q == H_M1);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_HDR;
          hdr_idx_d = 6'd0;
          col_d     = 12'd0;
          row_d     = 12'd0;
          sel_d     = 2'd0;
          pad_d     = 2'd0;
          full_d    = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (xfer_s && (hdr_idx_q == 6'(HDR_BYTES - 1))) begin
          state_d = ST_PIX;
        end else if (xfer_s) begin
          hdr_idx_d = hdr_idx_q + 6'd1;
        end else begin
          state_d = ST_HDR;
        end
      end
      ST_PIX: begin
        // Capture and transfer are exclusive: one needs the hold register empty, the other full.
        if (cap_s) begin
          hold_d = pix_data;
          full_d = 1'b1;
          sel_d  = 2'd0;
        end else if (xfer_s && (sel_q != 2'd2)) begin
          sel_d = sel_q + 2'd1;
        end else if (xfer_s) begin
          full_d = 1'b0;
          sel_d  = 2'd0;
          if (!last_col_s) begin
            col_d = col_q + 12'd1;
          end else begin
            col_d = 12'd0;
            if (PAD_N != 2'd0) begin
              state_d = ST_PAD;
              pad_d   = 2'd0;
            end else if (last_row_s) begin
              state_d = ST_FIN;
            end else begin
              row_d = row_q + 12'd1;
            end
          end
        end else begin
          state_d = ST_PIX;
        end
      end
      ST_PAD: begin
        if (xfer_s && (pad_q != PAD_M1)) begin
          pad_d = pad_q + 2'd1;
        end else if (xfer_s) begin
          pad_d = 2'd0;
          if (last_row_s) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_PIX;
            row_d   = row_q + 12'd1;
          end
        end else begin
          state_d = ST_PAD;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from next-state values so every output leaves a flop.
  always_comb begin
`ifdef BMP_GRAYSCALE_EN
    pix_byte_s = gray_byte(hold_d);
`else
    case (sel_d)
      2'd0:    pix_byte_s = hold_d[7:0];
      2'd1:    pix_byte_s = hold_d[15:8];
      2'd2:    pix_byte_s = hold_d[23:16];
      default: pix_byte_s = 8'h00;
    endcase
`endif
    pix_ready_d = (state_d == ST_PIX) && !full_d;
    out_valid_d = (state_d == ST_HDR) || (state_d == ST_PAD) ||
                  ((state_d == ST_PIX) && full_d);
    case (state_d)
      ST_HDR:  out_data_d = hdr_byte_s;
      ST_PIX:  out_data_d = full_d ? pix_byte_s : 8'h00;
      default: out_data_d = 8'h00;
    endcase
    out_last_d = (row_d == H_M1) &&
                 (((state_d == ST_PAD) && (pad_d == PAD_M1)) ||
                  ((state_d == ST_PIX) && full_d && (sel_d == 2'd2) &&
                   (col_d == W_M1) && (PAD_N == 2'd0)));
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FIN);
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hdr_idx_q   <= 6'd0;
      col_q       <= 12'd0;
      row_q       <= 12'd0;
      sel_q       <= 2'd0;
      pad_q       <= 2'd0;
      hold_q      <= 24'd0;
      full_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_last_q  <= 1'b0;
      pix_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_idx_q   <= hdr_idx_d;
      col_q       <= col_d;
      row_q       <= row_d;
      sel_q       <= sel_d;
      pad_q       <= pad_d;
      hold_q      <= hold_d;
      full_q      <= full_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      pix_ready_q <= pix_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign pix_ready = pix_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_bmp_stream_writer.sv
// Scoreboard bench for bmp_stream_writer: a 3x2 instance for full frames, stalls
// and abort, plus a default-size instance for header field checks.
module tb_bmp_stream_writer;

  localparam int FLEN = 78;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, pix_valid, pix_ready, out_valid, out_last, busy, done;
  logic        out_ready = 1'b1;
  logic [23:0] pix_data;
  logic [7:0]  out_data;

  logic        d_rst, d_start, d_pix_ready, d_out_valid, d_out_last, d_busy, d_done;
  logic [7:0]  d_out_data;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] hdr_exp [54];
  logic [23:0] pix_tab [6];
  int  byte_cnt = 0;
  int  done_cnt = 0;
  bit  mon_en = 1'b0;
  bit  stall_en = 1'b0;
  bit  g_seen = 1'b0;
  bit  stall_pend = 1'b0;
  logic [8:0] stall_word;

  bmp_stream_writer #(.WIDTH(3), .HEIGHT(2)) u_dut (
    .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done)
  );

  bmp_stream_writer u_dut_def (
    .clk(clk), .rst(d_rst), .start(d_start), .pix_valid(1'b0), .pix_ready(d_pix_ready),
    .pix_data(24'd0), .out_valid(d_out_valid), .out_ready(1'b1), .out_data(d_out_data),
    .out_last(d_out_last), .busy(d_busy), .done(d_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    out_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: pops the scoreboard on every transfer and checks stall stability.
  always @(negedge clk) begin
    logic [7:0] e;
    if (mon_en) begin
      if (stall_pend)
        chk("stall_hold", 32'({out_valid, out_last, out_data}), 32'({1'b1, stall_word}));
      stall_pend = out_valid && !out_ready;
      stall_word = {out_last, out_data};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 32'(byte_cnt), 32'(FLEN));
        end else begin
          e = exp_q.pop_front();
          chk("byte", 32'(out_data), 32'(e));
        end
        chk("last", 32'(out_last), 32'(byte_cnt == FLEN - 1));
        if (byte_cnt == 70) g_seen = 1'b1;
        byte_cnt++;
      end
    end else begin
      stall_pend = 1'b0;
    end
    if (done) done_cnt++;
  end

  task automatic push_hdr();
    for (int i = 0; i < 54; i++) exp_q.push_back(hdr_exp[i]);
  endtask

  task automatic send_pix(input logic [23:0] p, input int idx);
    bit ok;
`ifdef BMP_GRAYSCALE_EN
    logic [9:0] y;
    y = (10'(p[23:16]) + 10'(p[15:8]) + 10'(p[15:8]) + 10'(p[7:0])) >> 2;
    for (int k = 0; k < 3; k++) exp_q.push_back(y[7:0]);
`else
    exp_q.push_back(p[7:0]);
    exp_q.push_back(p[15:8]);
    exp_q.push_back(p[23:16]);
`endif
    if (idx % 3 == 2) for (int k = 0; k < 3; k++) exp_q.push_back(8'h00);
    pix_data  = p;
    pix_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (pix_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    pix_valid = 1'b0;
    if (!ok) chk("pix_accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic start_frame(input bit stl);
    stall_en = stl;
    mon_en   = 1'b1;
    byte_cnt = 0;
    push_hdr();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_frame(input bit stl);
    int dc0;
    bit found;
    dc0 = done_cnt;
    start_frame(stl);
    for (int i = 0; i < 6; i++) send_pix(pix_tab[i], i);
    found = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (done) begin
        found = 1'b1;
        break;
      end
    end
    chk("done_seen", 32'(found), 32'd1);
    @(posedge clk); #1;
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("done_once", 32'(done_cnt - dc0), 32'd1);
    chk("frame_len", 32'(byte_cnt), 32'(FLEN));
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] dh [54];
    int n;
    int dc;
    bit found;
    int idx_tab [18] = '{0, 1, 2, 3, 4, 5, 18, 19, 20, 21, 22, 23, 24, 25, 28, 34, 35, 36};
    logic [7:0] val_tab [18] = '{8'h42, 8'h4D, 8'h36, 8'h00, 8'h12, 8'h00, 8'h00, 8'h03, 8'h00,
                                 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h18, 8'h00, 8'h00, 8'h12};

    for (int i = 0; i < 54; i++) hdr_exp[i] = 8'h00;
    hdr_exp[0] = 8'h42; hdr_exp[1] = 8'h4D; hdr_exp[2] = 8'h4E; hdr_exp[10] = 8'h36;
    hdr_exp[14] = 8'h28; hdr_exp[18] = 8'h03; hdr_exp[22] = 8'h02; hdr_exp[26] = 8'h01;
    hdr_exp[28] = 8'h18; hdr_exp[34] = 8'h18;
    pix_tab = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC, 24'hDDEEFF, 24'h4080C0};

    rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_data = 24'd0;
    d_rst = 1'b1; d_start = 1'b0;

    // Reset held three cycles with a start pulse inside it.
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_pix_ready", 32'(pix_ready), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_out_valid", 32'(out_valid), 32'd0);

    // Default-size header fields.
    d_rst = 1'b0;
    @(posedge clk); #1;
    d_start = 1'b1;
    @(posedge clk); #1;
    d_start = 1'b0;
    n = 0;
    for (int c = 0; c < 80 && n < 54; c++) begin
      if (d_out_valid) begin
        dh[n] = d_out_data;
        n++;
      end
      @(posedge clk); #1;
    end
    chk("def_hdr_len", 32'(n), 32'd54);
    for (int i = 0; i < 18; i++) chk($sformatf("def_hdr[%0d]", idx_tab[i]), 32'(dh[idx_tab[i]]), 32'(val_tab[i]));
    chk("def_hdr[37]", 32'(dh[37]), 32'h00);
    d_rst = 1'b1;

    run_frame(1'b0);
    run_frame(1'b1);

    // Abort after the G byte of the fifth pixel.
    g_seen = 1'b0;
    start_frame(1'b0);
    for (int i = 0; i < 5; i++) send_pix(pix_tab[i], i);
    found = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(posedge clk);
      if (g_seen) begin
        found = 1'b1;
        break;
      end
    end
    chk("g5_seen", 32'(found), 32'd1);
    #1;
    mon_en = 1'b0;
    rst = 1'b1;
    dc = done_cnt;
    @(posedge clk); #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_out_data", 32'(out_data), 32'd0);
    chk("abort_out_last", 32'(out_last), 32'd0);
    chk("abort_pix_ready", 32'(pix_ready), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt - dc), 32'd0);

    run_frame(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bmp_stream_writer.md
BMP_STREAM_WRITER -- requirements
Module: bmp_stream_writer

Interface
REQ-001 SHALL have parameter WIDTH, default 768, image width in pixels (1..4095).
REQ-002 SHALL have parameter HEIGHT, default 512, image height in pixels (1..4095).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  single-cycle pulse that begins one BMP file.
REQ-006 SHALL have port pix_valid  input  1  upstream pixel valid.
REQ-007 SHALL have port pix_ready  output  1  block accepts pixel.
REQ-008 SHALL have port pix_data  input  24  pixel {R[23:16],G[15:8],B[7:0]}, bottom row first.
REQ-009 SHALL have port out_valid  output  1  output byte valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts byte.
REQ-011 SHALL have port out_data  output  8  file byte.
REQ-012 SHALL have port out_last  output  1  marks final file byte.
REQ-013 SHALL have port busy  output  1  high from start acceptance until done.
REQ-014 SHALL have port done  output  1  one-cycle pulse after last byte transfers.

Function
REQ-015 SHALL implement FSM IDLE -> HDR -> PIX <-> PAD -> FIN -> IDLE.
- IDLE->HDR: start=1.
- HDR->PIX: 54th header byte transfers.
- PIX->PAD: last pixel byte of a row transfers and PAD>0.
- PAD->PIX: last pad byte transfers and more rows remain.
- PIX/PAD->FIN: last byte of last row transfers.
- FIN->IDLE: after one cycle; done=1 in FIN.
REQ-016 SHALL ignore start when not in IDLE.
REQ-017 SHALL emit the 54-byte header, little-endian multi-byte fields:
- 'B','M' (0x42,0x4D).
- File size = 54+ROWB*HEIGHT, where ROWB=3*WIDTH+PAD and PAD=(4-(3*WIDTH mod 4)) mod 4.
- Reserved 0; data offset 54; DIB size 40; WIDTH; HEIGHT.
- Planes 1 (16-bit); bpp 24 (16-bit); compression 0.
- Image size ROWB*HEIGHT.
- Bytes 38..53 zero.
REQ-018 SHALL transfer a byte only on out_valid && out_ready.
REQ-019 SHALL hold out_data/out_last stable while out_valid && !out_ready.
REQ-020 SHALL assert pix_ready only in PIX while the 24-bit hold register is empty.
REQ-021 SHALL capture a pixel on pix_valid && pix_ready, marking the hold register full.
REQ-022 SHALL present the captured pixel's B byte on the next cycle, then G, then R.
REQ-023 SHALL free the hold register when the R byte transfers.
REQ-024 SHALL emit PAD zero bytes after each row's last R byte.
REQ-025 SHALL keep out_valid low in PIX while the hold register is empty (bubble permitted).
REQ-026 SHALL assert out_last only with the final byte (54+ROWB*HEIGHT-th).
REQ-027 SHALL size byte/pixel/row counters for the maximum parameters; no wrap within a frame.

Reset
REQ-028 SHALL, on rst=1 at a clk edge, force state IDLE, all counters 0, hold register empty.
REQ-029 SHALL, on reset, force pix_ready, out_valid, out_data, out_last, busy and done to 0.
REQ-030 SHALL treat reset mid-frame as an abort: no done pulse; the next start restarts at header byte 0.

Configuration
REQ-031 SHALL, with BMP_GRAYSCALE_EN defined, emit Y=(R+2G+B)>>2 (10-bit sum, truncated) for all three colour bytes; header is unchanged.
REQ-032 SHALL, with BMP_GRAYSCALE_EN undefined, emit raw B,G,R bytes.

Structure
REQ-033 SHALL place the FSM state enum, HDR_BYTES=54 constant and PAD/ROWB/file-size functions in shared package bmp_pkg.
REQ-034 SHALL use one combinational sub-module, bmp_header_rom: header index (6b) plus WIDTH/HEIGHT yields the header byte.

Verification
REQ-035 SHALL cover: rst held 3 cycles -> all outputs 0, state IDLE; start during reset ignored.
REQ-036 SHALL cover: default params, out_ready=1 -> bytes 0..5 = 42 4D 36 00 12 00, bytes 18..25 = 00 03 00 00 00 02 00 00, byte 28 = 0x18, bytes 34..37 = 00 00 12 00.
REQ-037 SHALL cover: WIDTH=3, HEIGHT=2, pixels 0x112233 ... -> first pixel bytes 33 22 11; 3 zero pad bytes per row; 78 bytes total; out_last on byte 78; done pulses exactly once, next cycle busy=0.
REQ-038 SHALL cover: out_ready randomly 50% low -> byte sequence identical to the unstalled run; out_data unchanged on every stalled cycle.
REQ-039 SHALL cover: rst asserted after G byte of pixel 5 -> outputs 0 next cycle, no done; a new start reproduces the full file from 0x42.
REQ-040 SHALL cover: pixel 0x4080C0 -> with BMP_GRAYSCALE_EN 80 80 80; without it C0 80 40.
